// File: rtl/lsu_dmem_if.sv
// Load/store request and response bus between the core and the data-memory LSU.
interface lsu_dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    // Core side: issues requests, sees the response and the PC-hold stall.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    // LSU side.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface

// File: rtl/lsu_dmem.sv
// Load/store unit with an integrated word-organised data memory (DEPTH x 32).
// Handles byte/half/word loads and stores with lane strobes, sign/zero extension,
// misalignment/illegal/range checks and a configurable access latency.
module lsu_dmem #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned MEM_LATENCY = 0
) (
    input  logic      clk,
    input  logic      reset,
    lsu_dmem_if.slave bus
);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        w_latch, w_access;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    // Name fixed so benches can reach the array hierarchically.
    logic [31:0] RAM [DEPTH];

    logic             w_acc_we;
    logic [2:0]       w_acc_funct3;
    logic [31:0]      w_acc_addr, w_acc_wdata;
    logic [IDX_W-1:0] w_idx;
    logic             w_misalign, w_illegal, w_oor, w_err;
    logic [31:0]      w_rd_word, w_ld_data;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [3:0]       w_wmask;
    logic [31:0]      w_wdata_al;

    assign bus.req_ready = (r_state == StIdle);
    assign bus.stall     = ((r_state == StIdle) && bus.req_valid) || (r_state == StWait);
    assign bus.rsp_valid = (r_state == StResp);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    // With zero latency the access happens on the accept edge, so use the live inputs.
    assign w_acc_we     = (r_state == StIdle) ? bus.req_we     : r_we;
    assign w_acc_funct3 = (r_state == StIdle) ? bus.req_funct3 : r_funct3;
    assign w_acc_addr   = (r_state == StIdle) ? bus.req_addr   : r_addr;
    assign w_acc_wdata  = (r_state == StIdle) ? bus.req_wdata  : r_wdata;

    assign w_idx     = w_acc_addr[IDX_W+1:2];
    // Full upper address is compared, so aliasing above the array is an error.
    assign w_oor     = (w_acc_addr[31:2] >= DEPTH_W);
    assign w_err     = w_misalign || w_illegal || w_oor;
    assign w_rd_word = RAM[w_idx];

    // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_access    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.req_valid) begin
                    w_latch = 1'b1;
                    if (MEM_LATENCY == 0) begin
                        w_access    = 1'b1;
                        w_state_nxt = StResp;
                    end else begin
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = StWait;
                    end
                end
            end
            StWait: begin
                if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = StResp;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            StResp:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Misalignment and illegal-encoding checks on the access operands.
    always_comb begin
        w_misalign = 1'b0;
        w_illegal  = 1'b0;
        case (w_acc_funct3)
            3'b000, 3'b100: w_misalign = 1'b0;
            3'b001, 3'b101: w_misalign = w_acc_addr[0];
            3'b010:         w_misalign = |w_acc_addr[1:0];
            default:        w_illegal  = 1'b1;
        endcase
        // Unsigned widths have no store form.
        if (w_acc_we && w_acc_funct3[2]) begin
            w_illegal = 1'b1;
        end
    end

    // Load lane extraction and extension.
    always_comb begin
        w_byte = 8'h00;
        case (w_acc_addr[1:0])
            2'd0: w_byte = w_rd_word[7:0];
            2'd1: w_byte = w_rd_word[15:8];
            2'd2: w_byte = w_rd_word[23:16];
            2'd3: w_byte = w_rd_word[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = w_acc_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        case (w_acc_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'h0, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'h0, w_half};
            3'b010:  w_ld_data = w_rd_word;
            default: w_ld_data = 32'h0;
        endcase
    end

    // Store byte strobes with store data replicated onto every lane.
    always_comb begin
        w_wmask    = 4'b1111;
        w_wdata_al = w_acc_wdata;
        case (w_acc_funct3[1:0])
            2'b00: begin
                w_wmask    = 4'b0001 << w_acc_addr[1:0];
                w_wdata_al = {4{w_acc_wdata[7:0]}};
            end
            2'b01: begin
                w_wmask    = w_acc_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_al = {2{w_acc_wdata[15:0]}};
            end
            default: begin
                w_wmask    = 4'b1111;
                w_wdata_al = w_acc_wdata;
            end
        endcase
    end

    // Control state, latched request and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
            end
            if (w_access) begin
                r_rdata <= (w_err || w_acc_we) ? 32'h0 : w_ld_data;
                r_err   <= w_err;
            end
        end
    end

    // Array write port; contents survive reset, and reset blocks any pending write.
    always_ff @(posedge clk) begin
        if (w_access && !reset && w_acc_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) begin
                    RAM[w_idx][b*8 +: 8] <= w_wdata_al[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: three instances at latencies 0, 3 and 5 share one request
// stream, steered by sel. Expected responses go through a scoreboard queue.
module tb_lsu_dmem;
    logic        clk = 1'b0;
    logic        reset;
    int          sel;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        m_req_ready, m_rsp_valid, m_rsp_err, m_stall;
    logic [31:0] m_rsp_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t sb_q[$];

    lsu_dmem_if if0();
    lsu_dmem_if if1();
    lsu_dmem_if if2();

    assign if0.req_valid = req_valid && (sel == 0);
    assign if1.req_valid = req_valid && (sel == 1);
    assign if2.req_valid = req_valid && (sel == 2);
    assign if0.req_we = req_we;  assign if0.req_funct3 = req_funct3;
    assign if0.req_addr = req_addr;  assign if0.req_wdata = req_wdata;
    assign if1.req_we = req_we;  assign if1.req_funct3 = req_funct3;
    assign if1.req_addr = req_addr;  assign if1.req_wdata = req_wdata;
    assign if2.req_we = req_we;  assign if2.req_funct3 = req_funct3;
    assign if2.req_addr = req_addr;  assign if2.req_wdata = req_wdata;

    lsu_dmem #(.DEPTH(256), .MEM_LATENCY(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    lsu_dmem #(.DEPTH(256), .MEM_LATENCY(3)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    lsu_dmem #(.DEPTH(256), .MEM_LATENCY(5)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            1: begin
                m_req_ready = if1.req_ready; m_rsp_valid = if1.rsp_valid;
                m_rsp_err = if1.rsp_err; m_stall = if1.stall; m_rsp_rdata = if1.rsp_rdata;
            end
            2: begin
                m_req_ready = if2.req_ready; m_rsp_valid = if2.rsp_valid;
                m_rsp_err = if2.rsp_err; m_stall = if2.stall; m_rsp_rdata = if2.rsp_rdata;
            end
            default: begin
                m_req_ready = if0.req_ready; m_rsp_valid = if0.rsp_valid;
                m_rsp_err = if0.rsp_err; m_stall = if0.stall; m_rsp_rdata = if0.rsp_rdata;
            end
        endcase
    end

    function automatic logic [31:0] ram_word(input int s, input logic [7:0] idx);
        case (s)
            1:       return u_dut1.RAM[idx];
            2:       return u_dut2.RAM[idx];
            default: return u_dut0.RAM[idx];
        endcase
    endfunction

    function automatic int exp_lat(input int s);
        case (s)
            1:       return 3;
            2:       return 5;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with the target unit idle.
    task automatic do_req(input int s, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input logic hold,
                          input logic chk_ram, input logic [7:0] ram_idx,
                          input logic [31:0] ram_old);
        rsp_t e;
        rsp_t got;
        logic seen;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        sel = s; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge clk);
        check("accept_ready", 32'(m_req_ready), 32'd1);
        check("accept_stall", 32'(m_stall), 32'd1);
        check("accept_no_rsp", 32'(m_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (m_rsp_valid) begin
                seen = 1'b1;
                check("latency", 32'(n), 32'(exp_lat(s)));
                check("rsp_stall", 32'(m_stall), 32'd0);
                check("rsp_ready", 32'(m_req_ready), 32'd0);
            end else begin
                check("wait_stall", 32'(m_stall), 32'd1);
                if (chk_ram) check("ram_before_access", ram_word(s, ram_idx), ram_old);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL rsp_timeout: observed no rsp_valid expected pulse");
            void'(sb_q.pop_front());
        end else begin
            got = sb_q.pop_front();
            check("rsp_rdata", m_rsp_rdata, got.rdata);
            check("rsp_err", 32'(m_rsp_err), 32'(got.err));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sel = 0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        #6;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_ready", 32'(m_req_ready), 32'd1);
            check("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
            check("rst_rdata", m_rsp_rdata, 32'h0);
            check("rst_err", 32'(m_rsp_err), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Latency 0: preload via stores, then extension cases.
        do_req(0, 1, 3'b010, 32'd100, 32'h8081_F2F3, 32'h0, 0, 0, 0, 8'd0, 32'h0);
        do_req(0, 1, 3'b010, 32'd96, 32'h1122_3344, 32'h0, 0, 0, 0, 8'd0, 32'h0);
        do_req(0, 1, 3'b010, 32'd0, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 8'd0, 32'h0);
        check("ram25_preload", ram_word(0, 8'd25), 32'h8081_F2F3);
        do_req(0, 0, 3'b000, 32'd100, 32'h0, 32'hFFFF_FFF3, 0, 0, 0, 8'd0, 32'h0);
        do_req(0, 0, 3'b100, 32'd101, 32'h0, 32'h0000_00F2, 0, 0, 0, 8'd0, 32'h0);
        do_req(0, 0, 3'b001, 32'd102, 32'h0, 32'hFFFF_8081, 0, 0, 0, 8'd0, 32'h0);
        do_req(0, 0, 3'b101, 32'd102, 32'h0, 32'h0000_8081, 0, 0, 0, 8'd0, 32'h0);
        do_req(0, 0, 3'b010, 32'd100, 32'h0, 32'h8081_F2F3, 0, 0, 0, 8'd0, 32'h0);

        // Error cases.
        do_req(0, 0, 3'b010, 32'd102, 32'h0, 32'h0, 1, 0, 0, 8'd0, 32'h0);
        do_req(0, 1, 3'b001, 32'd99, 32'h0000_BEEF, 32'h0, 1, 0, 0, 8'd0, 32'h0);
        check("ram24_after_bad_sh", ram_word(0, 8'd24), 32'h1122_3344);
        do_req(0, 0, 3'b011, 32'd100, 32'h0, 32'h0, 1, 0, 0, 8'd0, 32'h0);
        do_req(0, 1, 3'b100, 32'd96, 32'h0000_00FF, 32'h0, 1, 0, 0, 8'd0, 32'h0);
        check("ram24_after_bad_sbu", ram_word(0, 8'd24), 32'h1122_3344);
        do_req(0, 1, 3'b010, 32'h400, 32'h0000_0019, 32'h0, 1, 0, 0, 8'd0, 32'h0);
        check("ram0_after_oor", ram_word(0, 8'd0), 32'hCAFE_F00D);
        do_req(0, 0, 3'b010, 32'h8000_0064, 32'h0, 32'h0, 1, 0, 0, 8'd0, 32'h0);

        // Back-to-back with req_valid held high.
        do_req(0, 0, 3'b010, 32'd100, 32'h0, 32'h8081_F2F3, 0, 1, 0, 8'd0, 32'h0);
        do_req(0, 1, 3'b010, 32'd104, 32'h1234_5678, 32'h0, 0, 1, 0, 8'd0, 32'h0);
        do_req(0, 0, 3'b010, 32'd104, 32'h0, 32'h1234_5678, 0, 0, 0, 8'd0, 32'h0);

        // Latency 3: word store timing and lane stores.
        do_req(1, 1, 3'b010, 32'd100, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 8'd0, 32'h0);
        do_req(1, 1, 3'b010, 32'd100, 32'h0000_0019, 32'h0, 0, 0, 1, 8'd25, 32'hDEAD_BEEF);
        check("ram25_sw", ram_word(1, 8'd25), 32'h0000_0019);
        do_req(1, 1, 3'b010, 32'd96, 32'h1122_3344, 32'h0, 0, 0, 0, 8'd0, 32'h0);
        do_req(1, 1, 3'b000, 32'd97, 32'h0000_00AB, 32'h0, 0, 0, 1, 8'd24, 32'h1122_3344);
        check("ram24_sb", ram_word(1, 8'd24), 32'h1122_AB44);
        do_req(1, 1, 3'b001, 32'd98, 32'h0000_BEEF, 32'h0, 0, 0, 0, 8'd0, 32'h0);
        check("ram24_sh", ram_word(1, 8'd24), 32'hBEEF_AB44);
        do_req(1, 0, 3'b000, 32'd99, 32'h0, 32'hFFFF_FFBE, 0, 0, 0, 8'd0, 32'h0);

        // Latency 5: reset during WAIT discards the pending store.
        do_req(2, 1, 3'b010, 32'd8, 32'h5555_AAAA, 32'h0, 0, 0, 0, 8'd0, 32'h0);
        do_req(2, 0, 3'b010, 32'd8, 32'h0, 32'h5555_AAAA, 0, 0, 0, 8'd0, 32'h0);
        sel = 2; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd8;
        req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wait_stall_pre_rst", 32'(m_stall), 32'd1);
        req_addr = 32'd100; req_wdata = 32'h0;
        reset = 1'b1;
        #1;
        check("rst_mid_rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("rst_mid_rdata", m_rsp_rdata, 32'h0);
        check("rst_mid_err", 32'(m_rsp_err), 32'd0);
        check("rst_mid_stall", 32'(m_stall), 32'd0);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_ready", 32'(m_req_ready), 32'd1);
        check("post_rst_ram2", ram_word(2, 8'd2), 32'h5555_AAAA);
        do_req(2, 0, 3'b010, 32'd8, 32'h0, 32'h5555_AAAA, 0, 0, 0, 8'd0, 32'h0);

        check("sb_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
- Parametrised load/store unit with an integrated word-organised data memory, for the single-cycle RV32 core. It replaces the fixed word-only, zero-latency data memory.
- Supports lb/lh/lw/lbu/lhu/sb/sh/sw with byte-lane strobes, sign and zero extension, and misalignment, illegal-width and range checks.
- Supports a configurable access latency. A stall output holds the PC register, which is a flop with enable, until the access completes.

Parameters:
- DEPTH, 256, number of 32-bit words in the array; must be a power of two, minimum 4.
- MEM_LATENCY, 0, extra wait cycles before the array access; range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  load/store request present (core's decoded lw/sw-class opcode).
- req_ready  out  1  unit can accept a request (state IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: misaligned, illegal funct3, or out of range.
- stall  out  1  core must hold PC and must not write back while high.

Behaviour:
- State machine: IDLE, WAIT, RESP.
  - req_ready = (state == IDLE).
  - stall = (IDLE & req_valid) | WAIT.
  - rsp_valid = (state == RESP).
- Accept: on an edge with IDLE & req_valid, latch we, funct3, addr and wdata.
  - Next state is WAIT with cnt = MEM_LATENCY-1 when MEM_LATENCY>0.
  - Otherwise the array access is performed on that same edge and next state is RESP.
- WAIT:
  - cnt decrements each edge.
  - On the edge where cnt == 0, the array access is performed on the latched request and state goes to RESP.
- RESP: lasts exactly one cycle, then returns to IDLE regardless of req_valid.
  - The core advances its PC on the RESP edge; the next instruction's request is seen in IDLE the following cycle.
- Timing: rsp_valid is high in the (MEM_LATENCY+1)th cycle after the accept cycle. A memory instruction therefore occupies MEM_LATENCY+2 cycles.
- Error checks, evaluated at the access edge:
  - Misaligned: h/hu with addr[0]=1, or w with addr[1:0]!=0.
  - Illegal: funct3 in {011,110,111}, or a store with funct3 in {100,101}.
  - Out of range: addr[31:2] >= DEPTH.
  - Any error: no array write; rsp_rdata=0; rsp_err=1.
- Store strobes, word index addr[31:2]:
  - sb writes lane addr[1:0] with wdata[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - sw writes all four lanes with wdata.
  - Unselected bytes are preserved.
- Load extraction: lane selected by addr[1:0].
  - lb and lh sign-extend bit 7 and bit 15 respectively.
  - lbu and lhu zero-extend.
  - lw passes the whole word.
- rsp_rdata and rsp_err are registered at the access edge and held until the next access edge. They are meaningful only while rsp_valid is high.
- Array: named RAM, DEPTH x 32, so benches can preload it hierarchically. Contents are not cleared by reset.
- Reset, asynchronous, at any time:
  - state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - A latched request whose access edge has not occurred is discarded; its store never writes.
- Request inputs are ignored outside IDLE. Changes to req_* during WAIT do not affect the latched request.
- Width rule: all extension is to 32 bits; address bits above the index range are checked, never truncated silently.

Test Plan:
- MEM_LATENCY=0; preload RAM[25]=0x8081_F2F3:
  - lb addr 100 -> rsp_valid 1 cycle after accept, rdata 0xFFFF_FFF3.
  - lbu addr 101 -> 0x0000_00F2.
  - lh addr 102 -> 0xFFFF_8081.
  - lhu addr 102 -> 0x0000_8081.
- MEM_LATENCY=3: sw 0x0000_0019 to addr 100 -> stall high for 4 cycles, rsp_valid in cycle 4, rsp_err 0; RAM[25] changes only at the access edge.
- Preload RAM[24]=0x1122_3344:
  - sb 0xAB to addr 97 -> RAM[24]=0x1122_AB44.
  - Then sh 0xBEEF to addr 98 -> RAM[24]=0xBEEF_AB44.
- Error cases:
  - lw addr 102 -> rsp_err 1, rdata 0.
  - sh addr 99 -> rsp_err 1, RAM unchanged.
  - funct3 011 -> rsp_err 1.
  - With DEPTH=256, sw addr 0x400 -> rsp_err 1, no write.
- MEM_LATENCY=5: sw accepted, then reset asserted during WAIT for 1 ns -> outputs return to reset values immediately, target word unchanged, req_ready 1 after reset release.
- Back-to-back with MEM_LATENCY=0: lw, sw, lw issued consecutively, holding req_valid through IDLE -> each completes in 2 cycles, rsp_valid pulses every other cycle, and the second lw returns the stored value.
